// File: rtl/sigma_delta_pkg.sv
// Shared constants for the multi-channel sigma-delta DAC: accumulator headroom
// and the supported modulator orders.
package sigma_delta_pkg;
   localparam int ACC_GUARD    = 4;
   localparam int ORDER_FIRST  = 1;
   localparam int ORDER_SECOND = 2;
endpackage

// File: rtl/sigma_delta_mod_ch.sv
// One DAC channel: linear interpolation between the previous and current sample,
// followed by a first- or second-order 1-bit sigma-delta modulator.
module sigma_delta_mod_ch
   import sigma_delta_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ORDER     = ORDER_SECOND,
   parameter int STEP_LOG2 = 9,
   parameter bit INV       = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [STEP_LOG2-1:0] step,
   input  logic                 advance,
   input  logic                 loadCur,
   input  logic [WIDTH-1:0]     sampleIn,
   output logic                 dacBit
);
   localparam int AW = WIDTH + ACC_GUARD;
   localparam int IW = WIDTH + STEP_LOG2 + 1;
   localparam int SW = AW + 2;
   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [SW-1:0] FB_MAG  = SW'(1) <<< (WIDTH - 1);

   logic signed [WIDTH-1:0] prev, cur, target;
   logic signed [IW-1:0]    diff, stepExt, scaled;
   logic signed [AW-1:0]    acc1, acc2, acc1Next, acc2Next;
   logic signed [SW-1:0]    fb, acc1Sum, acc2Sum;
   logic                    outBit, outNext;

   function automatic logic signed [AW-1:0] saturate(input logic signed [SW-1:0] x);
      if (x > SW'(ACC_MAX)) return ACC_MAX;
      if (x < SW'(ACC_MIN)) return ACC_MIN;
      return AW'(x);
   endfunction

   // The register holds the already-inverted pin value; undo INV to recover the modulator bit.
   assign outBit = dacBit ^ INV;

   always_comb begin
      diff     = IW'(cur) - IW'(prev);
      stepExt  = signed'(IW'(step));
      scaled   = (diff * stepExt) >>> STEP_LOG2;
      target   = WIDTH'(IW'(prev) + scaled);
      fb       = outBit ? FB_MAG : -FB_MAG;
      acc1Sum  = SW'(acc1) + SW'(target) - fb;
      acc2Sum  = SW'(acc2) + SW'(acc1) - fb;
      acc1Next = saturate(acc1Sum);
      acc2Next = saturate(acc2Sum);
      outNext  = (ORDER == ORDER_FIRST) ? !acc1Next[AW-1] : !acc2Next[AW-1];
   end

   // NOTE: every register below is updated with <= so all of them see the pre-edge values of each other.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         prev   <= '0;
         cur    <= '0;
         acc1   <= '0;
         acc2   <= '0;
         dacBit <= INV;
      end else begin
         if (advance) prev <= cur;
         if (loadCur) cur  <= sampleIn;
         acc1   <= acc1Next;
         acc2   <= (ORDER == ORDER_FIRST) ? '0 : acc2Next;
         dacBit <= outNext ^ INV;
      end
   end
endmodule

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC: shared step counter and one-deep sample buffer
// feeding CHANNELS identical interpolating modulators.
module sigma_delta_dac_mc
   import sigma_delta_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 2,
   parameter int ORDER     = ORDER_SECOND,
   parameter int STEP_LOG2 = 9,
   parameter bit INV       = 1'b1
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [CHANNELS*WIDTH-1:0] sample_data,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   output logic                      underrun,
   output logic [CHANNELS-1:0]       dac_out
);
   logic [STEP_LOG2-1:0]      step;
   logic [CHANNELS*WIDTH-1:0] pending;
   logic                      pendingFull;
   logic                      lastStep, accept, loadCur;

   assign lastStep     = (step == '1);
   assign sample_ready = !pendingFull;
   assign accept       = sample_valid && !pendingFull;
   assign loadCur      = lastStep && pendingFull;
   // Decoded from registered state so the pulse lines up with the boundary cycle itself.
   assign underrun     = lastStep && !pendingFull;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         step        <= '0;
         pending     <= '0;
         pendingFull <= 1'b0;
      end else begin
         step <= step + STEP_LOG2'(1);
         if (accept) begin
            pending     <= sample_data;
            pendingFull <= 1'b1;
         end else if (loadCur) begin
            pendingFull <= 1'b0;
         end
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : genChannel
      sigma_delta_mod_ch #(
         .WIDTH     (WIDTH),
         .ORDER     (ORDER),
         .STEP_LOG2 (STEP_LOG2),
         .INV       (INV)
      ) uChannel (
         .CLK      (CLK),
         .RESET    (RESET),
         .step     (step),
         .advance  (lastStep),
         .loadCur  (loadCur),
         .sampleIn (pending[n*WIDTH +: WIDTH]),
         .dacBit   (dac_out[n])
      );
   end
endmodule
